jtframe_snd_dac: RTL and testbench



---
 rtl/jtframe_snd_dac.sv | 116 +++++++++++
 tb/tb_jtframe_snd_dac.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/jtframe_snd_dac.sv
// Multi-channel sound DAC: shared attenuation, soft-mute gain ramp and first-order sigma-delta per channel; JTFRAME_SND_DITHER_EN adds LFSR dither.
// Latency: snd sampled on cen pulse k shapes dac_out on cen pulse k+1.
// No backpressure: one sample per channel consumed on every cen; everything frozen while cen is low.
module jtframe_snd_dac #(
  parameter int CHANNELS   = 2,
  parameter int SNDW       = 16,
  parameter int SIGNED_SND = 1,
  parameter int RAMPW      = 6
) (
  input  logic                     clk_dac,
  input  logic                     rst_n,
  input  logic                     cen,
  input  logic [CHANNELS*SNDW-1:0] snd,
  input  logic [2:0]               att,
  input  logic                     mute,
  output logic [CHANNELS-1:0]      dac_out,
  output logic                     muted
);
  localparam int PW = SNDW + 11;
  localparam logic [SNDW-1:0] MID  = {1'b1, {(SNDW-1){1'b0}}};
  localparam logic [SNDW-1:0] FLIP = (SIGNED_SND != 0) ? MID : '0;

  typedef enum logic [1:0] {ST_ON, ST_DOWN, ST_MUTED, ST_UP} state_t;

  state_t           state, state_nxt;
  logic [8:0]       gain, gain_nxt;
  logic [RAMPW-1:0] tick_cnt;
  logic             tick;
  logic [1:0]       dith;

  assign tick  = cen & (&tick_cnt);
  assign muted = (state == ST_MUTED);

  // Mute-direction changes never step the gain; a step that lands on a rail switches state on the same tick.
  always_comb begin
    state_nxt = state;
    gain_nxt  = gain;
    if (tick) begin
      case (state)
        ST_ON:    if (mute) state_nxt = ST_DOWN;
        ST_DOWN: begin
          if (!mute) state_nxt = ST_UP;
          else begin
            gain_nxt = gain - 9'd1;
            if (gain == 9'd1) state_nxt = ST_MUTED;
          end
        end
        ST_MUTED: if (!mute) state_nxt = ST_UP;
        ST_UP: begin
          if (mute) state_nxt = ST_DOWN;
          else begin
            gain_nxt = gain + 9'd1;
            if (gain == 9'd255) state_nxt = ST_ON;
          end
        end
        default:  state_nxt = ST_MUTED;
      endcase
    end
  end

  always_ff @(posedge clk_dac) begin
    if (!rst_n) begin
      state    <= ST_MUTED;
      gain     <= '0;
      tick_cnt <= '0;
    end else if (cen) begin
      state    <= state_nxt;
      gain     <= gain_nxt;
      tick_cnt <= tick_cnt + RAMPW'(1);
    end
  end

`ifdef JTFRAME_SND_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_dac) begin
    if (!rst_n) lfsr <= 16'h0001;
    else if (cen) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign dith = lfsr[1:0];
`else
  assign dith = 2'd0;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SNDW-1:0]      u, x, x_nxt, acc;
    logic signed [SNDW:0] s, s_a;
    logic [SNDW+1:0]      sum;
    logic                 bit_out;

    // |gain| <= 256 keeps the scaled sample inside the unsigned range, so no clamp is needed.
    always_comb begin
      u     = snd[i*SNDW +: SNDW] ^ FLIP;
      s     = $signed({1'b0, u}) - $signed({1'b0, MID});
      s_a   = s >>> att;
      x_nxt = SNDW'((PW'(s_a) * PW'($signed({1'b0, gain}))) >>> 8) + MID;
      sum   = {2'b00, acc} + {2'b00, x} + (SNDW+2)'(dith);
    end

    always_ff @(posedge clk_dac) begin
      if (!rst_n) begin
        x       <= MID;
        acc     <= '0;
        bit_out <= 1'b0;
      end else if (cen) begin
        x       <= x_nxt;
        acc     <= sum[SNDW-1:0];
        bit_out <= |sum[SNDW+1:SNDW];
      end
    end

    assign dac_out[i] = bit_out;
  end

endmodule

// File: tb/tb_jtframe_snd_dac.sv
// Scoreboarded bench for jtframe_snd_dac: integer reference model pushes expected outputs, a monitor compares each cycle.
module tb_jtframe_snd_dac;
  localparam int CH    = 2;
  localparam int W     = 16;
  localparam int RW    = 2;
  localparam int FULL  = 1 << W;
  localparam int HALF  = 1 << (W - 1);
  localparam int RAMPN = 1 << RW;
  localparam int MD_ON = 0, MD_DOWN = 1, MD_MUTED = 2, MD_UP = 3;

  logic            clk_dac = 1'b0;
  logic            rst_n = 1'b0;
  logic            cen = 1'b0;
  logic [CH*W-1:0] snd = '0;
  logic [2:0]      att = '0;
  logic            mute = 1'b0;
  logic [CH-1:0]   dac_out;
  logic            muted;

  jtframe_snd_dac #(.CHANNELS(CH), .SNDW(W), .SIGNED_SND(1), .RAMPW(RW)) dut (
    .clk_dac(clk_dac), .rst_n(rst_n), .cen(cen), .snd(snd),
    .att(att), .mute(mute), .dac_out(dac_out), .muted(muted)
  );

  always #5 clk_dac = ~clk_dac;

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q[$];
  bit counting = 0;
  int ones0 = 0, ones1 = 0;

  // Reference model state, kept as plain integers
  int m_acc[CH];
  int m_x[CH];
  bit m_out[CH];
  int m_gain, m_cnt, m_mode;

  function automatic int ref_x(input int raw, input int a, input int g);
    int s, sa;
    s = (raw >= HALF) ? raw - FULL : raw;
    sa = s >>> a;
    return ((sa * g) >>> 8) + HALF;
  endfunction

  task automatic step(input logic r, input logic c, input logic [31:0] sv, input logic [2:0] a, input logic m);
    @(negedge clk_dac);
    rst_n = r; cen = c; snd = sv; att = a; mute = m;
    if (!r) begin
      for (int ch = 0; ch < CH; ch++) begin
        m_acc[ch] = 0; m_x[ch] = HALF; m_out[ch] = 0;
      end
      m_gain = 0; m_cnt = 0; m_mode = MD_MUTED;
    end else if (c) begin
      for (int ch = 0; ch < CH; ch++) begin
        int tot;
        tot = m_acc[ch] + m_x[ch];
        m_out[ch] = (tot >= FULL);
        m_acc[ch] = tot % FULL;
        m_x[ch] = ref_x(int'(sv[ch*W +: W]), int'(a), m_gain);
      end
      if (m_cnt == RAMPN - 1) begin
        case (m_mode)
          MD_ON:    if (m) m_mode = MD_DOWN;
          MD_DOWN:  if (!m) m_mode = MD_UP;
                    else begin m_gain--; if (m_gain == 0) m_mode = MD_MUTED; end
          MD_MUTED: if (!m) m_mode = MD_UP;
          default:  if (m) m_mode = MD_DOWN;
                    else begin m_gain++; if (m_gain == 256) m_mode = MD_ON; end
        endcase
      end
      m_cnt = (m_cnt + 1) % RAMPN;
    end
    exp_q.push_back({m_mode == MD_MUTED, m_out[1], m_out[0]});
  endtask

  // Monitor: one expected entry per clock edge that had stimulus
  always @(posedge clk_dac) begin
    logic [2:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({muted, dac_out} !== e) begin
        failures++;
        $display("FAIL out_cycle t=%0t got muted,dac_out=%b expected %b", $time, {muted, dac_out}, e);
      end
      if (counting) begin
        ones0 += int'(dac_out[0]);
        ones1 += int'(dac_out[1]);
      end
    end
  end

  initial begin
    int n;
    bit seen;
    logic [31:0] sv;

    repeat (3) step(1'b0, 1'b1, 32'h0, 3'd0, 1'b0);
    // Ramp up to ON with midscale input: alternating 0/1 throughout
    repeat (1100) step(1'b1, 1'b1, 32'h0, 3'd0, 1'b0);
    repeat (300) step(1'b1, 1'b1, 32'h7FFF_7FFF, 3'd0, 1'b0);
    repeat (300) step(1'b1, 1'b1, 32'h8000_8000, 3'd0, 1'b0);

    // Exact duty over one full accumulator period: ch0 0x4000 -> x=0xA000, ch1 0xC000 -> x=0x6000
    repeat (2) step(1'b1, 1'b1, 32'hC000_4000, 3'd1, 1'b0);
    step(1'b1, 1'b1, 32'hC000_4000, 3'd1, 1'b0);
    counting = 1;
    repeat (65535) step(1'b1, 1'b1, 32'hC000_4000, 3'd1, 1'b0);
    @(posedge clk_dac); #2;
    counting = 0;
    checks++;
    if (ones0 != 40960) begin
      failures++;
      $display("FAIL duty_ch0 got %0d ones expected 40960", ones0);
    end
    checks++;
    if (ones1 != 24576) begin
      failures++;
      $display("FAIL duty_ch1 got %0d ones expected 24576", ones1);
    end

    repeat (500) step(1'b1, 1'b1, 32'hC000_4000, 3'd7, 1'b0);

    // cen one in three, random samples
    sv = $urandom;
    for (int i = 0; i < 900; i++) begin
      if (i % 3 == 0) sv = $urandom;
      step(1'b1, (i % 3 == 0), sv, 3'd0, 1'b0);
    end

    // Full soft mute from ON: 256 decrement ticks after the ON->DOWN tick
    seen = 0; n = 0;
    for (int i = 1; i <= 1300 && !seen; i++) begin
      step(1'b1, 1'b1, $urandom, 3'($urandom_range(0, 7)), 1'b1);
      @(posedge clk_dac); #2;
      if (muted) begin seen = 1; n = i; end
    end
    checks++;
    if (!seen || n < 1025 || n > 1028) begin
      failures++;
      $display("FAIL mute_latency got %0d cycles (seen=%0d) expected 1025..1028", n, seen);
    end

    repeat (1100) step(1'b1, 1'b1, $urandom, 3'd0, 1'b0);
    // Reverse the ramp mid-way at gain 100
    for (int i = 0; i < 2000 && !(m_mode == MD_DOWN && m_gain == 100); i++)
      step(1'b1, 1'b1, $urandom, 3'd2, 1'b1);
    repeat (156 * RAMPN + 8) step(1'b1, 1'b1, $urandom, 3'd2, 1'b0);

    // Reset asserted mid-DOWN
    repeat (200) step(1'b1, 1'b1, $urandom, 3'd0, 1'b1);
    step(1'b0, 1'b1, $urandom, 3'd0, 1'b1);
    step(1'b1, 1'b0, $urandom, 3'd0, 1'b1);

    // Random soak
    begin
      logic mv;
      mv = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 399) == 0) mv = ~mv;
        step(($urandom_range(0, 1999) != 0), ($urandom_range(0, 3) != 0), $urandom,
             3'($urandom_range(0, 7)), mv);
      end
    end

    repeat (3) @(posedge clk_dac);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
